// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
// Purpose : bundles the two SRAM-like master ports (inst_*, data_*) and the
//           shared bridge port (bus_*) of sram_port_arbiter.
// Modports:
//   slave  - arbiter view: master requests and bridge responses in,
//            master handshakes/read data and bridge request out.
//   master - environment view (masters plus bridge), directions mirrored.
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if;

   // instruction-fetch master
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [31:0] inst_wdata;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   // MEM-stage data master
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   // shared bridge port
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;

   modport slave (
      input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      input  bus_rdata, bus_addr_ok, bus_data_ok,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output bus_req, bus_wr, bus_size, bus_addr, bus_wdata
   );

   modport master (
      output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      output bus_rdata, bus_addr_ok, bus_data_ok,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata
   );

endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Purpose : shares one SRAM-like bridge port between the instruction-fetch
//           master and the data master, one transaction at a time
//           (address phase, then data phase). Data has priority; after
//           STARVE_LIMIT consecutive data grants with inst pending, inst wins.
// Ports   :
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   sif  - sram_port_arbiter_if.slave (inst_*, data_*, bus_* signals)
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4   // legal range 1..15
) (
   input logic                clk,
   input logic                rst,
   sram_port_arbiter_if.slave sif
);

   localparam int unsigned STREAK_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_owner;    // 0 = inst, 1 = data
   logic [STREAK_W-1:0] r_streak;   // consecutive data grants while inst waits

   logic w_arb;
   logic w_starved;
   logic w_win_data;
   logic w_win_inst;

   // Arbitration happens when idle or on the cycle the current transfer ends.
   assign w_arb      = (r_state == S_IDLE) || ((r_state == S_DATA) && sif.bus_data_ok);
   assign w_starved  = sif.inst_req && (r_streak == STREAK_W'(STARVE_LIMIT));
   assign w_win_data = sif.data_req && !w_starved;
   assign w_win_inst = !w_win_data && sif.inst_req;

   // State, owner and starvation streak.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_owner  <= 1'b0;
         r_streak <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DATA: begin
               if (w_arb) begin
                  if (w_win_data) begin
                     r_state <= S_ADDR;
                     r_owner <= 1'b1;
                     if (!sif.inst_req)
                        r_streak <= '0;
                     else if (r_streak != STREAK_W'(STARVE_LIMIT))
                        r_streak <= r_streak + STREAK_W'(1);
                  end else if (w_win_inst) begin
                     r_state  <= S_ADDR;
                     r_owner  <= 1'b0;
                     r_streak <= '0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_ADDR: begin
               if (sif.bus_addr_ok)
                  r_state <= S_DATA;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Bridge request mux and handshake routing back to the owner only.
   always_comb begin
      sif.bus_req      = 1'b0;
      sif.bus_wr       = 1'b0;
      sif.bus_size     = 2'd0;
      sif.bus_addr     = 32'd0;
      sif.bus_wdata    = 32'd0;
      sif.inst_addr_ok = 1'b0;
      sif.data_addr_ok = 1'b0;
      sif.inst_data_ok = 1'b0;
      sif.data_data_ok = 1'b0;
      sif.inst_rdata   = sif.bus_rdata;
      sif.data_rdata   = sif.bus_rdata;

      if (r_state == S_ADDR) begin
         sif.bus_req = 1'b1;
         if (r_owner) begin
            sif.bus_wr       = sif.data_wr;
            sif.bus_size     = sif.data_size;
            sif.bus_addr     = sif.data_addr;
            sif.bus_wdata    = sif.data_wdata;
            sif.data_addr_ok = sif.bus_addr_ok;
         end else begin
            sif.bus_wr       = sif.inst_wr;
            sif.bus_size     = sif.inst_size;
            sif.bus_addr     = sif.inst_addr;
            sif.bus_wdata    = sif.inst_wdata;
            sif.inst_addr_ok = sif.bus_addr_ok;
         end
      end

      if (r_state == S_DATA) begin
         if (r_owner)
            sif.data_data_ok = sif.bus_data_ok;
         else
            sif.inst_data_ok = sif.bus_data_ok;
      end
   end

endmodule
